// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit: PC, I-cache request/valid handshake, redirect and freeze |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Alt_PC_IN,
  input  logic        Request_Alt_PC_IN,
  input  logic        WANT_FREEZE_IN,
  output logic [31:0] IMem_Addr,
  output logic        IMem_Req,
  input  logic [31:0] IMem_Data,
  input  logic        IMem_Valid,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT,
  output logic        hit
);

  typedef enum logic [0:0] {RUN = 1'b0, MISS = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] miss_addr_q, miss_addr_d;
  logic        prev_hit_q, prev_hit_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic        hit_q, hit_d;

  logic        redir, frz, req;
  logic [31:0] fa, addr_raw, dlv_addr;

  always_comb begin
    // A request seen without a preceding hit was held through a miss and is already consumed.
    redir    = Request_Alt_PC_IN & prev_hit_q;
    frz      = WANT_FREEZE_IN & hit_q;
    fa       = redir ? Alt_PC_IN : (pend_v_q ? pend_addr_q : pc_q);
    dlv_addr = (state_q == MISS) ? miss_addr_q : fa;

    state_d     = state_q;
    pc_d        = pc_q;
    miss_addr_d = miss_addr_q;
    prev_hit_d  = hit_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    ipc4_d      = ipc4_q;
    hit_d       = hit_q;
    req         = 1'b1;
    addr_raw    = fa;

    case (state_q)
      RUN: begin
        if (frz) begin
          req = 1'b0;
          if (redir) begin
            pend_v_d    = 1'b1;
            pend_addr_d = Alt_PC_IN;
          end
        end else if (!IMem_Valid) begin
          miss_addr_d = fa;
          pend_v_d    = 1'b0;
          hit_d       = 1'b0;
          state_d     = MISS;
        end
      end
      MISS: begin
        addr_raw = miss_addr_q;
        hit_d    = 1'b0;
        if (IMem_Valid) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (IMem_Valid && (state_q == MISS || !frz)) begin
      instr_d  = IMem_Data;
      ipc_d    = dlv_addr;
      ipc4_d   = dlv_addr + 32'd4;
      pc_d     = dlv_addr + 32'd4;
      hit_d    = 1'b1;
      pend_v_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      miss_addr_q <= 32'd0;
      prev_hit_q  <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= 32'd0;
      instr_q     <= 32'd0;
      ipc_q       <= 32'd0;
      ipc4_q      <= 32'd0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      miss_addr_q <= miss_addr_d;
      prev_hit_q  <= prev_hit_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      instr_q     <= instr_d;
      ipc_q       <= ipc_d;
      ipc4_q      <= ipc4_d;
      hit_q       <= hit_d;
    end
  end

  assign IMem_Addr          = {addr_raw[31:2], 2'b00};
  assign IMem_Req           = req;
  assign Instr1_OUT         = instr_q;
  assign Instr_PC_OUT       = ipc_q;
  assign Instr_PC_Plus4_OUT = ipc4_q;
  assign hit                = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit: directed bench with a next-address reference model    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h00400000;
  localparam logic [31:0] KEY      = 32'hDEADBEEF;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] Alt_PC_IN = 32'd0;
  logic        Request_Alt_PC_IN = 1'b0;
  logic        WANT_FREEZE_IN = 1'b0;
  logic        IMem_Valid = 1'b1;
  logic [31:0] IMem_Addr;
  logic        IMem_Req;
  logic [31:0] IMem_Data;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4_OUT;
  logic        hit;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // The memory returns a word derived from the address it was asked for.
  assign IMem_Data = IMem_Addr ^ KEY;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RESET(RESET),
    .Alt_PC_IN(Alt_PC_IN), .Request_Alt_PC_IN(Request_Alt_PC_IN),
    .WANT_FREEZE_IN(WANT_FREEZE_IN),
    .IMem_Addr(IMem_Addr), .IMem_Req(IMem_Req),
    .IMem_Data(IMem_Data), .IMem_Valid(IMem_Valid),
    .Instr1_OUT(Instr1_OUT), .Instr_PC_OUT(Instr_PC_OUT),
    .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT), .hit(hit)
  );

  always #5 CLK = ~CLK;

  // Model: one "next address to fetch" (a pending redirect simply replaces it)
  // plus a flag saying that address is an outstanding miss.
  logic [31:0] m_next, m_instr, m_ipc, m_ipc4;
  bit          m_hit, m_prev_hit, m_missing;

  task automatic model_reset();
    m_next = RESET_PC; m_missing = 0; m_hit = 0; m_prev_hit = 0;
    m_instr = 0; m_ipc = 0; m_ipc4 = 0;
  endtask

  task automatic model_deliver(input logic [31:0] a);
    m_hit = 1; m_instr = {a[31:2], 2'b00} ^ KEY; m_ipc = a; m_ipc4 = a + 32'd4;
    m_next = a + 32'd4; m_missing = 0;
  endtask

  task automatic model_step();
    bit old_hit, redir, frz;
    logic [31:0] a;
    old_hit = m_hit;
    redir = Request_Alt_PC_IN && m_prev_hit;
    frz   = WANT_FREEZE_IN && m_hit;
    if (m_missing) begin
      if (IMem_Valid) model_deliver(m_next);
    end else begin
      a = redir ? Alt_PC_IN : m_next;
      if (frz) begin
        if (redir) m_next = Alt_PC_IN;
      end else if (IMem_Valid) begin
        model_deliver(a);
      end else begin
        m_next = a; m_missing = 1; m_hit = 0;
      end
    end
    m_prev_hit = old_hit;
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    bit exp_req;
    logic [31:0] exp_addr;
    if (chk_en) begin
      exp_req  = m_missing || !(WANT_FREEZE_IN && m_hit);
      exp_addr = (!m_missing && Request_Alt_PC_IN && m_prev_hit) ? Alt_PC_IN : m_next;
      cmp("model_req", {31'd0, IMem_Req}, {31'd0, exp_req});
      if (exp_req) cmp("model_addr", IMem_Addr, {exp_addr[31:2], 2'b00});
      cmp("model_hit", {31'd0, hit}, {31'd0, m_hit});
      cmp("model_instr", Instr1_OUT, m_instr);
      cmp("model_pc", Instr_PC_OUT, m_ipc);
      cmp("model_pc4", Instr_PC_Plus4_OUT, m_ipc4);
    end
  end

  task automatic drive(input bit v, input bit r, input logic [31:0] alt, input bit f);
    IMem_Valid = v; Request_Alt_PC_IN = r; Alt_PC_IN = alt; WANT_FREEZE_IN = f;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RESET) model_step();
    #1;
  endtask

  task automatic fetch_ck(input string nm, input logic [31:0] a);
    #1; cmp(nm, IMem_Addr, a); tick();
  endtask

  initial begin
    drive(1, 0, 0, 0);
    #2 RESET = 1'b0;
    model_reset();
    chk_en = 1'b1;
    tick(); tick(); tick();
    cmp("rst_hit", {31'd0, hit}, 32'd0);
    cmp("rst_pc", Instr_PC_OUT, 32'd0);
    cmp("rst_pc4", Instr_PC_Plus4_OUT, 32'd0);
    cmp("rst_instr", Instr1_OUT, 32'd0);

    RESET = 1'b1;
    fetch_ck("first_addr", 32'h00400000);
    cmp("first_pc", Instr_PC_OUT, 32'h00400000);
    cmp("first_pc4", Instr_PC_Plus4_OUT, 32'h00400004);
    cmp("first_hit", {31'd0, hit}, 32'd1);
    cmp("first_instr", Instr1_OUT, 32'h00400000 ^ KEY);
    fetch_ck("second_addr", 32'h00400004);

    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      fetch_ck("miss_addr_held", 32'h00400008);
      cmp("miss_hit_low", {31'd0, hit}, 32'd0);
    end
    drive(1, 0, 0, 0);
    fetch_ck("miss_fill_addr", 32'h00400008);
    cmp("miss_fill_pc", Instr_PC_OUT, 32'h00400008);
    tick();
    cmp("after_miss_pc", Instr_PC_OUT, 32'h0040000C);

    tick(); tick();
    cmp("slot_pc", Instr_PC_OUT, 32'h00400014);
    drive(1, 1, 32'h00400100, 0);
    fetch_ck("redir_addr", 32'h00400100);
    cmp("redir_pc", Instr_PC_OUT, 32'h00400100);
    drive(1, 0, 0, 0);
    tick();
    cmp("redir_next_pc", Instr_PC_OUT, 32'h00400104);

    tick(); tick();
    drive(0, 1, 32'h00400300, 0);
    fetch_ck("stale_target_addr", 32'h00400300);
    tick();
    drive(1, 1, 32'h00400300, 0);
    tick();
    cmp("stale_fill_pc", Instr_PC_OUT, 32'h00400300);
    tick();
    cmp("stale_ignored_pc", Instr_PC_OUT, 32'h00400304);

    for (int i = 0; i < 4; i++) begin
      drive(1, i == 1, 32'h00400200, 1);
      #1;
      cmp("frz_req", {31'd0, IMem_Req}, 32'd0);
      tick();
      cmp("frz_pc_held", Instr_PC_OUT, 32'h00400304);
      cmp("frz_hit", {31'd0, hit}, 32'd1);
    end
    drive(1, 0, 0, 0);
    fetch_ck("pend_addr", 32'h00400200);
    cmp("pend_pc", Instr_PC_OUT, 32'h00400200);

    tick();
    drive(1, 1, 32'hFFFFFFFC, 0);
    tick();
    cmp("wrap_pc4", Instr_PC_Plus4_OUT, 32'h00000000);
    drive(1, 0, 0, 0);
    tick();
    cmp("wrap_pc", Instr_PC_OUT, 32'h00000000);

    drive(0, 1, 32'h00400040, 0);
    fetch_ck("mm_addr", 32'h00400040);
    drive(0, 0, 0, 0);
    tick();
    RESET = 1'b0;
    model_reset();
    #1;
    cmp("mm_rst_hit", {31'd0, hit}, 32'd0);
    cmp("mm_rst_pc", Instr_PC_OUT, 32'd0);
    cmp("mm_rst_instr", Instr1_OUT, 32'd0);
    tick(); tick();
    drive(1, 0, 0, 0);
    RESET = 1'b1;
    fetch_ck("mm_first_addr", 32'h00400000);
    cmp("mm_first_pc", Instr_PC_OUT, 32'h00400000);

    for (int i = 0; i < 24; i++) begin
      drive((i % 3) != 0, (i % 4) == 2, 32'h00001000 + 32'(i) * 32'd16, (i % 5) == 1);
      tick();
    end

    @(negedge CLK);
    #1 chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
